reg_file_param: RTL and testbench

Parametrised general-purpose register file: the successor to the fixed 8×8 file. It has two combinational read ports and one synchronous write port with its own write address, plus same-cycle write-to-read forwarding. A block-transfer engine loads the whole file from data memory, or saves it to data memory, starting at a given address. It sits between the decoder/ALU datapath and the data memory port of the core.

---
 rtl/reg_file_param.sv | 139 +++++++++++++
 tb/tb_reg_file_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports with write forwarding, one write port,
// and a block engine that loads the file from, or saves it to, data memory (load DEPTH+2, save DEPTH+1 cycles to done).
module reg_file_param #(
   parameter int  WIDTH  = 8,
   parameter int  DEPTH  = 8,
   parameter int  MEM_AW = 7,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              save,
   input  logic [MEM_AW-1:0] start_address,
   input  logic              write,
   input  logic [AW-1:0]     waddr,
   input  logic [WIDTH-1:0]  writeData,
   input  logic [AW-1:0]     src1,
   input  logic [AW-1:0]     src2,
   output logic [WIDTH-1:0]  readData1,
   output logic [WIDTH-1:0]  readData2,
   output logic              busy,
   output logic              done,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_we,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DRAIN = 3'd2,
      S_STORE = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   localparam logic [AW:0]   LAST_I  = (AW+1)'(DEPTH-1);
   localparam logic [AW-1:0] TOP_IDX = AW'(DEPTH-1);

   state_t              state_q, state_d;
   logic [AW:0]         i_q, i_d;
   logic [MEM_AW-1:0]   base_q, base_d;
   logic [WIDTH-1:0]    regs_q [DEPTH];
   logic [WIDTH-1:0]    regs_d [DEPTH];

   logic                wr_en;
   logic [AW-1:0]       ld_idx;

   assign busy   = (state_q != S_IDLE);
   assign wr_en  = write & ~busy;
   // Data returning this cycle belongs to the address issued one cycle earlier.
   assign ld_idx = i_q[AW-1:0] - AW'(1);

   assign readData1 = (wr_en && (waddr == src1)) ? writeData : regs_q[src1];
   assign readData2 = (wr_en && (waddr == src2)) ? writeData : regs_q[src2];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         base_q  <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            regs_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         base_q  <= base_d;
         for (int k = 0; k < DEPTH; k++) begin
            regs_q[k] <= regs_d[k];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      base_d  = base_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = save ? S_STORE : S_LOAD;
               base_d  = start_address;
               i_d     = '0;
            end
         end
         S_LOAD: begin
            i_d = i_q + 1'b1;
            if (i_q == LAST_I) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: state_d = S_FIN;
         S_STORE: begin
            i_d = i_q + 1'b1;
            if (i_q == LAST_I) begin
               state_d = S_FIN;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         regs_d[k] = regs_q[k];
      end
      if (wr_en) begin
         regs_d[waddr] = writeData;
      end
      if ((state_q == S_LOAD) && (i_q != '0)) begin
         regs_d[ld_idx] = mem_rdata;
      end
      if (state_q == S_DRAIN) begin
         regs_d[TOP_IDX] = mem_rdata;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      done      = 1'b0;
      case (state_q)
         S_LOAD: begin
            mem_addr = base_q + MEM_AW'(i_q);
         end
         S_STORE: begin
            mem_addr  = base_q + MEM_AW'(i_q);
            mem_we    = 1'b1;
            mem_wdata = regs_q[i_q[AW-1:0]];
         end
         S_FIN:   done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: default 8x8 instance plus a 16-bit x 4 instance, random traffic against an array model.
module tb_reg_file_param;

   localparam int W   = 8;
   localparam int D   = 8;
   localparam int AWA = 3;
   localparam int MAW = 7;
   localparam int WB  = 16;
   localparam int DB  = 4;
   localparam int AWB = 2;

   logic clock = 1'b0;
   always #10 clock = ~clock;
   logic reset_n;

   logic           start, save, write, busy, done, mem_we;
   logic [MAW-1:0] start_address, mem_addr;
   logic [AWA-1:0] waddr, src1, src2;
   logic [W-1:0]   writeData, readData1, readData2, mem_wdata, mem_rdata;

   logic            start_b, save_b, write_b, busy_b, done_b, mem_we_b;
   logic [MAW-1:0]  start_address_b, mem_addr_b;
   logic [AWB-1:0]  waddr_b, src1_b, src2_b;
   logic [WB-1:0]   writeData_b, readData1_b, readData2_b, mem_wdata_b, mem_rdata_b;

   reg_file_param dut_a (
      .clock(clock), .reset_n(reset_n), .start(start), .save(save),
      .start_address(start_address), .write(write), .waddr(waddr),
      .writeData(writeData), .src1(src1), .src2(src2),
      .readData1(readData1), .readData2(readData2), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   reg_file_param #(.WIDTH(WB), .DEPTH(DB), .MEM_AW(MAW)) dut_b (
      .clock(clock), .reset_n(reset_n), .start(start_b), .save(save_b),
      .start_address(start_address_b), .write(write_b), .waddr(waddr_b),
      .writeData(writeData_b), .src1(src1_b), .src2(src2_b),
      .readData1(readData1_b), .readData2(readData2_b), .busy(busy_b), .done(done_b),
      .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
   );

   // Synchronous-read data memories; contents are preloaded stimulus only.
   logic [W-1:0]  mem_a [128];
   logic [WB-1:0] mem_b [128];
   always @(posedge clock) mem_rdata   <= mem_a[mem_addr];
   always @(posedge clock) mem_rdata_b <= mem_b[mem_addr_b];

   logic [W-1:0]  ref_a [D];
   logic [WB-1:0] ref_b [DB];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reads_a(input string tag);
      write = 1'b0;
      for (int k = 0; k < D; k++) begin
         src1 = AWA'(k);
         src2 = AWA'(D-1-k);
         #1;
         check({tag, "_rd1"}, 32'(readData1), 32'(ref_a[k]));
         check({tag, "_rd2"}, 32'(readData2), 32'(ref_a[D-1-k]));
      end
   endtask

   task automatic check_reads_b(input string tag);
      write_b = 1'b0;
      for (int k = 0; k < DB; k++) begin
         src1_b = AWB'(k);
         src2_b = AWB'(DB-1-k);
         #1;
         check({tag, "_rd1"}, 32'(readData1_b), 32'(ref_b[k]));
         check({tag, "_rd2"}, 32'(readData2_b), 32'(ref_b[DB-1-k]));
      end
   endtask

   task automatic write_a(input int a, input int d);
      write = 1'b1; waddr = AWA'(a); writeData = W'(d);
      ref_a[a] = W'(d);
      tick();
      write = 1'b0;
   endtask

   task automatic write_b_reg(input int a, input int d);
      write_b = 1'b1; waddr_b = AWB'(a); writeData_b = WB'(d);
      ref_b[a] = WB'(d);
      tick();
      write_b = 1'b0;
   endtask

   task automatic clear_model();
      for (int k = 0; k < D; k++) ref_a[k] = '0;
      for (int k = 0; k < DB; k++) ref_b[k] = '0;
   endtask

   task automatic xfer_a(input logic sv, input logic [MAW-1:0] base, input bit wr0);
      logic           got_done;
      logic [AWA-1:0] wa;
      logic [W-1:0]   wd;
      logic [MAW-1:0] ea;
      got_done = 1'b0;
      start = 1'b1; save = sv; start_address = base;
      wa = AWA'($urandom); wd = W'($urandom);
      write = wr0; waddr = wa; writeData = wd;
      #2;
      check("a_busy_c0", 32'(busy), 32'(0));
      if (wr0) ref_a[wa] = wd;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 40 && !got_done; c++) begin
         // Writes while busy must be dropped; the model never applies them.
         write = 1'($urandom_range(0, 1)); waddr = AWA'($urandom); writeData = W'($urandom);
         @(negedge clock);
         if (c <= D) begin
            ea = base + MAW'(c-1);
            check("a_busy", 32'(busy), 32'(1));
            check("a_mem_we", 32'(mem_we), 32'(sv));
            check("a_mem_addr", 32'(mem_addr), 32'(ea));
            if (sv) check("a_mem_wdata", 32'(mem_wdata), 32'(ref_a[c-1]));
         end
         if (done) begin
            got_done = 1'b1;
            check("a_done_cycle", c, sv ? D+1 : D+2);
         end
         tick();
      end
      write = 1'b0;
      if (!got_done) check("a_done_timeout", 32'(0), 32'(1));
      #1;
      check("a_busy_after", 32'(busy), 32'(0));
      check("a_done_pulse", 32'(done), 32'(0));
      if (!sv) for (int k = 0; k < D; k++) begin
         ea = base + MAW'(k);
         ref_a[k] = mem_a[ea];
      end
      check_reads_a(sv ? "a_after_save" : "a_after_load");
      tick();
   endtask

   task automatic xfer_b(input logic sv, input logic [MAW-1:0] base);
      logic           got_done;
      logic [MAW-1:0] ea;
      got_done = 1'b0;
      start_b = 1'b1; save_b = sv; start_address_b = base;
      tick();
      start_b = 1'b0;
      for (int c = 1; c <= 40 && !got_done; c++) begin
         write_b = 1'($urandom_range(0, 1)); waddr_b = AWB'($urandom); writeData_b = WB'($urandom);
         @(negedge clock);
         if (c <= DB) begin
            ea = base + MAW'(c-1);
            check("b_mem_we", 32'(mem_we_b), 32'(sv));
            check("b_mem_addr", 32'(mem_addr_b), 32'(ea));
            if (sv) check("b_mem_wdata", 32'(mem_wdata_b), 32'(ref_b[c-1]));
         end
         if (done_b) begin
            got_done = 1'b1;
            check("b_done_cycle", c, sv ? DB+1 : DB+2);
         end
         tick();
      end
      write_b = 1'b0;
      if (!got_done) check("b_done_timeout", 32'(0), 32'(1));
      #1;
      check("b_busy_after", 32'(busy_b), 32'(0));
      if (!sv) for (int k = 0; k < DB; k++) begin
         ea = base + MAW'(k);
         ref_b[k] = mem_b[ea];
      end
      check_reads_b(sv ? "b_after_save" : "b_after_load");
      tick();
   endtask

   initial begin
      logic [W-1:0] e1, e2;
      start = 0; save = 0; write = 0; start_address = '0; waddr = '0; writeData = '0;
      src1 = '0; src2 = '0;
      start_b = 0; save_b = 0; write_b = 0; start_address_b = '0; waddr_b = '0;
      writeData_b = '0; src1_b = '0; src2_b = '0;
      for (int k = 0; k < 128; k++) begin
         mem_a[k] = W'($urandom);
         mem_b[k] = WB'($urandom);
      end
      for (int k = 0; k < 8; k++) mem_a[10+k] = W'(8'h10 + k);
      clear_model();

      reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_mem_we", 32'(mem_we), 32'(0));
      check("rst_mem_addr", 32'(mem_addr), 32'(0));
      check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
      check_reads_a("rst_a");
      check_reads_b("rst_b");
      tick();

      // Forwarding in the write cycle, then register readback.
      write = 1; waddr = 3'd2; writeData = 8'd63; src1 = 3'd2; src2 = 3'd1;
      #2;
      check("fwd_rd1", 32'(readData1), 32'd63);
      check("fwd_rd2", 32'(readData2), 32'd0);
      ref_a[2] = 8'd63;
      tick();
      write = 0;
      #1;
      check("wr_rd1", 32'(readData1), 32'd63);
      check("wr_rd2", 32'(readData2), 32'd0);
      write_a(4, 31);
      src1 = 3'd4; src2 = 3'd2;
      #1;
      check("wr2_rd1", 32'(readData1), 32'd31);
      check("wr2_rd2", 32'(readData2), 32'd63);
      tick();

      xfer_a(1'b0, 7'd10, 1'b0);
      for (int k = 0; k < D; k++) write_a(k, 8'hA0 + k);
      xfer_a(1'b1, 7'd124, 1'b0);

      // Random register traffic against the array model.
      repeat (60) begin
         write = 1'($urandom_range(0, 1)); waddr = AWA'($urandom); writeData = W'($urandom);
         src1 = AWA'($urandom); src2 = AWA'($urandom);
         #2;
         e1 = (write && waddr == src1) ? writeData : ref_a[src1];
         e2 = (write && waddr == src2) ? writeData : ref_a[src2];
         check("rnd_rd1", 32'(readData1), 32'(e1));
         check("rnd_rd2", 32'(readData2), 32'(e2));
         if (write) ref_a[waddr] = writeData;
         tick();
      end
      write = 0;

      repeat (4) xfer_a(1'($urandom), MAW'($urandom), 1'b1);

      // Reset in the 4th LOAD cycle.
      start = 1; save = 0; start_address = 7'd40;
      tick();
      start = 0;
      repeat (3) tick();
      check("mid_busy_pre", 32'(busy), 32'(1));
      reset_n = 1'b0;
      #1;
      clear_model();
      check("mid_busy", 32'(busy), 32'(0));
      check("mid_mem_we", 32'(mem_we), 32'(0));
      check("mid_mem_addr", 32'(mem_addr), 32'(0));
      check_reads_a("mid_rst");
      tick();
      reset_n = 1'b1;
      tick();
      xfer_a(1'b0, 7'd120, 1'b0);

      // 16-bit x 4 instance.
      xfer_b(1'b0, 7'd30);
      for (int k = 0; k < DB; k++) write_b_reg(k, 16'hBEE0 + k);
      xfer_b(1'b1, 7'd126);
      repeat (3) xfer_b(1'($urandom), MAW'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
